cpu6_clint: RTL and testbench
=============================

# cpu6_clint

Memory-mapped machine timer that responds to the cpu6 MEM-stage data port and drives the core's timer interrupt request. It holds a 64-bit `mtime` counter with a programmable prescaler and a 64-bit `mtimecmp` compare register. It raises `tmr_irq_r` whenever `mtime >= mtimecmp`. It sits beside data memory behind the address decode, and `tmr_irq_r` feeds the core's CSR/interrupt logic.

## Interface
- `BASE_ADDR`, default 32'h0200_0000: byte base of the 32-byte register window; must be 32-byte aligned.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `addr` in 32: byte address from the core's MEM-stage ALU result.
- `wdata` in 32: store data.
- `memwrite` in 1: store strobe, one cycle per store.
- `rdata` out 32: combinational read data for `addr`.
- `tmr_irq_r` out 1: registered timer interrupt request, level.

## Operation
- Hit: `hit = (addr[31:5] == BASE_ADDR[31:5])`. All accesses are word-sized and `addr[1:0]` is ignored.
- Register map, by offset `addr[4:2]`:
  - 0 `MTIME_LO`
  - 1 `MTIME_HI`
  - 2 `MTIMECMP_LO`
  - 3 `MTIMECMP_HI`
  - 4 `PRESCALE` (bits [7:0] used, [31:8] read 0)
  - 5–7 reserved: read 0, writes ignored.
- Reads: `rdata` is the selected register when `hit`, otherwise 0. Reads have no side effects.
- Writes: occur when `memwrite & hit`, at the next posedge. A miss writes nothing.
- Prescaler:
  - 8-bit `pcnt` counts up each cycle.
  - When `pcnt == PRESCALE`, `tick=1` and `pcnt` returns to 0.
  - `PRESCALE=0` gives a tick every cycle.
  - `PRESCALE=N` gives a tick every N+1 cycles.
- Counter: on `tick`, `mtime <= mtime + 1`, 64-bit, wrapping from all-ones to 0 with no flag.
- Write to `MTIME_LO` or `MTIME_HI`:
  - loads that half.
  - suppresses the increment of both halves in that cycle (write wins over tick).
  - leaves the other half unchanged.
- Write to `PRESCALE` loads the value and clears `pcnt` to 0 in the same cycle; no tick is generated that cycle.
- Compare: `tmr_irq_r <= (mtime >= mtimecmp)`, a 64-bit unsigned comparison on current register values.
- No interrupt acknowledge exists. Software clears the request by raising `mtimecmp` or lowering `mtime`.
- Reset values:
  - `mtime = 0`
  - `mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF`
  - `PRESCALE = 0`
  - `pcnt = 0`
  - `tmr_irq_r = 0`
  - `rdata` follows the reset register values combinationally.

## Timing
- Read latency 0: `rdata` is valid in the same cycle `addr` is presented, matching the core's combinational MEM-stage load.
- A write at edge k is visible on `rdata` from edge k onward.
- Irq latency: `mtime`/`mtimecmp` reaching the compare condition at edge k gives `tmr_irq_r=1` after edge k+1. Deassertion has the same one-cycle latency.
- Reset asserted mid-count returns all state to reset values at that edge. No increment or write takes effect in a reset cycle.
- Store to `MTIME_LO` while `MTIME_LO = FFFF_FFFF` and `tick=1`: the store wins and no carry propagates into `MTIME_HI`.
- Write-then-read of `MTIME_LO` in back-to-back cycles returns the written value, or written+1 if a tick occurred on the following edge.

## Structure
- Shared package / `defines.v`:
  - `CPU6_CLINT_OFS_*` offset constants (0–4).
  - `CPU6_CLINT_MTIMECMP_RST` (all-ones).
  - `CPU6_XLEN` (reused).
- One sub-module: `cpu6_clint_prescaler`. Inputs: `clk`, `reset`, 8-bit `prescale`, `clr`. Output: `tick`.
- Counter, compare register, register-file decode and irq flop stay in `cpu6_clint`.

## Test plan
- Reset, then read offsets 0, 4, 8, C, 10 → `0`, `0`, `FFFF_FFFF`, `FFFF_FFFF`, `0`; `tmr_irq_r=0`.
- `PRESCALE=0`, run 10 cycles after reset → `MTIME_LO=10`.
- Write `PRESCALE=3` → increments exactly every 4 cycles: `MTIME_LO` advances by 5 over 20 cycles.
- Write `MTIME_HI=0`, `MTIME_LO=FFFF_FFFF`, `PRESCALE=0`, wait one tick → `MTIME_HI=1`, `MTIME_LO=0`.
- Write `MTIMECMP_HI=0`, then `MTIMECMP_LO=20` with `mtime` at 5 → `tmr_irq_r` rises exactly one cycle after `mtime` reaches 20. Then write `MTIMECMP_LO=FFFF_FFFF` → irq falls one cycle later.
- Store to `BASE_ADDR+0x14` and to `BASE_ADDR+0x20` (miss) → no register changes; reads of the miss address return 0.
- Store `MTIME_LO=7` on a tick cycle → reads 7 (not 8) on the next cycle.
- Assert `reset` while `tmr_irq_r=1` → irq drops and `mtime=0` after that edge.

Source files
------------

// File: rtl/cpu6_clint_pkg.sv
// ============================================================================
// Module      : cpu6_clint_pkg
// Description : Shared constants for the cpu6 machine timer (CLINT).
//               - Register offsets within the 32-byte window, indexed by addr[4:2].
//               - The reset value of mtimecmp.
//               - The prescaler counter width.
//               - Datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu6_clint_pkg;

  localparam int CPU6_XLEN = 32;

  // Word offsets (addr[4:2]) of the timer registers
  localparam logic [2:0] CPU6_CLINT_OFS_MTIME_LO    = 3'd0;
  localparam logic [2:0] CPU6_CLINT_OFS_MTIME_HI    = 3'd1;
  localparam logic [2:0] CPU6_CLINT_OFS_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] CPU6_CLINT_OFS_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] CPU6_CLINT_OFS_PRESCALE    = 3'd4;

  // mtimecmp resets to all-ones so the interrupt stays quiet until software arms it
  localparam logic [63:0] CPU6_CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int CPU6_CLINT_PCNT_W = 8;

  // Address decode: the window is 32 bytes, so only bits [31:5] take part
  function automatic logic cpu6_clint_hit(input logic [31:0] addr,
                                          input logic [31:0] base);
    return (addr[31:5] == base[31:5]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu6_clint_prescaler.sv
// ============================================================================
// Module      : cpu6_clint_prescaler
// Description : Tick generator for the machine timer. An 8-bit counter runs
//               from 0 up to `prescale`. It emits a one-cycle `tick` on the
//               cycle it matches, then wraps to 0. This gives one tick every
//               prescale+1 cycles.
// Ports       : clk      - clock
//               reset    - synchronous active-high reset
//               prescale - divider setting (current register value)
//               clr      - restart the count at 0, no tick this cycle
//               tick     - single-cycle increment enable for mtime
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu6_clint_prescaler
  import cpu6_clint_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CPU6_CLINT_PCNT_W-1:0] prescale,
  input  logic                         clr,
  output logic                         tick
);

  logic [CPU6_CLINT_PCNT_W-1:0] pcnt_q;
  logic [CPU6_CLINT_PCNT_W-1:0] pcnt_d;

  always_comb begin
    tick   = 1'b0;
    pcnt_d = pcnt_q + 1'b1;
    if (clr) begin
      // A divider reload restarts the period cleanly and suppresses the tick
      pcnt_d = '0;
    end else if (pcnt_q == prescale) begin
      tick   = 1'b1;
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu6_clint.sv
// ============================================================================
// Module      : cpu6_clint
// Description : Memory-mapped machine timer for the cpu6 MEM-stage data port.
//               - 64-bit mtime advances on prescaler ticks.
//               - 64-bit mtimecmp holds the compare value.
//               - A registered level interrupt is raised while mtime >= mtimecmp.
//               - BASE_ADDR must be 32-byte aligned.
// Ports       : clk       - clock
//               reset     - synchronous active-high reset
//               addr      - byte address (word access, addr[1:0] ignored)
//               wdata     - store data
//               memwrite  - store strobe
//               rdata     - combinational read data, 0 on a miss
//               tmr_irq_r - registered timer interrupt request (level)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu6_clint
  import cpu6_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CPU6_XLEN-1:0] addr,
  input  logic [CPU6_XLEN-1:0] wdata,
  input  logic                 memwrite,
  output logic [CPU6_XLEN-1:0] rdata,
  output logic                 tmr_irq_r
);

  logic        hit;
  logic [2:0]  ofs;
  logic        wr_en;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_prescale;
  logic        tick;
  logic        unused_addr_lsb;

  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [7:0]  prescale_q, prescale_d;
  logic        irq_q,      irq_d;

  assign hit             = cpu6_clint_hit(addr, BASE_ADDR);
  assign ofs             = addr[4:2];
  assign wr_en           = memwrite & hit;
  assign unused_addr_lsb = ^addr[1:0];

  assign wr_mtime_lo = wr_en && (ofs == CPU6_CLINT_OFS_MTIME_LO);
  assign wr_mtime_hi = wr_en && (ofs == CPU6_CLINT_OFS_MTIME_HI);
  assign wr_cmp_lo   = wr_en && (ofs == CPU6_CLINT_OFS_MTIMECMP_LO);
  assign wr_cmp_hi   = wr_en && (ofs == CPU6_CLINT_OFS_MTIMECMP_HI);
  assign wr_prescale = wr_en && (ofs == CPU6_CLINT_OFS_PRESCALE);

  cpu6_clint_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .prescale (prescale_q),
    .clr      (wr_prescale),
    .tick     (tick)
  );

  // Next-state for the register file
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    prescale_d = prescale_q;

    // A store to either mtime half takes priority over the tick.
    // This keeps a carry out of the low half from reaching the high half.
    if (wr_mtime_lo) begin
      mtime_d[31:0] = wdata;
    end else if (wr_mtime_hi) begin
      mtime_d[63:32] = wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_cmp_lo) begin
      mtimecmp_d[31:0] = wdata;
    end
    if (wr_cmp_hi) begin
      mtimecmp_d[63:32] = wdata;
    end
    if (wr_prescale) begin
      prescale_d = wdata[7:0];
    end
  end

  // The compare uses current register values, so the request trails the condition by one edge
  assign irq_d = (mtime_q >= mtimecmp_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= CPU6_CLINT_MTIMECMP_RST;
      prescale_q <= 8'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      prescale_q <= prescale_d;
      irq_q      <= irq_d;
    end
  end

  // Combinational read port
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (ofs)
        CPU6_CLINT_OFS_MTIME_LO:    rdata = mtime_q[31:0];
        CPU6_CLINT_OFS_MTIME_HI:    rdata = mtime_q[63:32];
        CPU6_CLINT_OFS_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
        CPU6_CLINT_OFS_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
        CPU6_CLINT_OFS_PRESCALE:    rdata = {24'd0, prescale_q};
        default:                    rdata = '0;
      endcase
    end
  end

  assign tmr_irq_r = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu6_clint.sv
// ============================================================================
// Module      : tb_cpu6_clint
// Description : Self-checking bench for cpu6_clint. A cycle-level reference
//               model tracks the timer registers, and the DUT is compared with
//               it after every clock edge. Directed sequences add
//               hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu6_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tmr_irq_r;

  cpu6_clint #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .memwrite  (memwrite),
    .rdata     (rdata),
    .tmr_irq_r (tmr_irq_r)
  );

  always #10 clk = ~clk;

  int   n_cmp  = 0;
  int   n_bad  = 0;
  logic chk_en = 1'b0;

  // ---------------- reference model ----------------
  // The divider is modelled as "cycles since the last restart" modulo the period.
  logic [63:0] m_mtime = 64'd0;
  logic [63:0] m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [7:0]  m_pre   = 8'd0;
  int unsigned m_cyc   = 0;
  logic        m_irq   = 1'b0;
  logic        m_wr;
  logic [2:0]  m_ofs;
  logic        m_tick;

  always @(posedge clk) begin
    m_wr  = memwrite && (addr[31:5] == BASE[31:5]);
    m_ofs = addr[4:2];
    if (reset) begin
      m_mtime = 64'd0;
      m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_pre   = 8'd0;
      m_cyc   = 0;
      m_irq   = 1'b0;
    end else begin
      m_irq  = (m_mtime >= m_cmp);
      m_tick = ((m_cyc % (32'(m_pre) + 1)) == 32'(m_pre));
      if (m_wr && m_ofs == 3'd4) begin
        m_pre  = wdata[7:0];
        m_cyc  = 0;
        m_tick = 1'b0;
      end else begin
        m_cyc = m_cyc + 1;
      end
      if (m_wr && m_ofs == 3'd0)      m_mtime = {m_mtime[63:32], wdata};
      else if (m_wr && m_ofs == 3'd1) m_mtime = {wdata, m_mtime[31:0]};
      else if (m_tick)                m_mtime = m_mtime + 64'd1;
      if (m_wr && m_ofs == 3'd2) m_cmp = {m_cmp[63:32], wdata};
      if (m_wr && m_ofs == 3'd3) m_cmp = {wdata, m_cmp[31:0]};
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'd0;
    case (a[4:2])
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_mtime[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {24'd0, m_pre};
      default: return 32'd0;
    endcase
  endfunction

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      n_cmp = n_cmp + 1;
      if (rdata !== exp_rd(addr)) begin
        n_bad = n_bad + 1;
        $display("FAIL model_rdata t=%0t addr=%h got=%h exp=%h", $time, addr, rdata, exp_rd(addr));
      end
      n_cmp = n_cmp + 1;
      if (tmr_irq_r !== m_irq) begin
        n_bad = n_bad + 1;
        $display("FAIL model_irq t=%0t got=%b exp=%b", $time, tmr_irq_r, m_irq);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Called just after a negedge; settles the combinational read well before the next posedge
  task automatic rd(input logic [31:0] ofs, input logic [31:0] exp, input string name);
    addr = BASE + ofs;
    #1;
    chk(name, rdata, exp);
  endtask

  // Called between a negedge and the next posedge; the store lands on that posedge
  task automatic wr(input logic [31:0] ofs, input logic [31:0] data);
    addr     = BASE + ofs;
    wdata    = data;
    memwrite = 1'b1;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    memwrite = 1'b0;
    wdata    = 32'd0;
    addr     = BASE;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;

    // Reset values while reset is still held
    rd(32'h00, 32'h0000_0000, "rst_mtime_lo");
    rd(32'h04, 32'h0000_0000, "rst_mtime_hi");
    rd(32'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(32'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(32'h10, 32'h0000_0000, "rst_prescale");
    chk("rst_irq", {31'd0, tmr_irq_r}, 32'd0);

    // Prescale 0: one increment per cycle
    reset = 1'b0;
    addr  = BASE;
    repeat (10) @(negedge clk);
    rd(32'h00, 32'd10, "count_10_cycles");

    // Prescale 3 (upper store bits dropped): one increment every 4 cycles
    wr(32'h10, 32'hFFFF_FF03);
    rd(32'h10, 32'd3, "prescale_readback");
    rd(32'h00, 32'd10, "prescale_write_no_tick");
    repeat (20) @(negedge clk);
    rd(32'h00, 32'd15, "prescale3_20_cycles");

    // Carry from low half into high half
    wr(32'h10, 32'd0);
    wr(32'h04, 32'd0);
    wr(32'h00, 32'hFFFF_FFFF);
    rd(32'h04, 32'd0, "carry_hi_before");
    rd(32'h00, 32'hFFFF_FFFF, "carry_lo_before");
    @(negedge clk);
    rd(32'h04, 32'd1, "carry_hi_after");
    rd(32'h00, 32'd0, "carry_lo_after");

    // Interrupt assertion and deassertion latency
    wr(32'h04, 32'd0);
    wr(32'h00, 32'd5);
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'd20);
    rd(32'h00, 32'd7, "irq_start_mtime");
    chk("irq_start_low", {31'd0, tmr_irq_r}, 32'd0);
    repeat (13) @(negedge clk);
    rd(32'h00, 32'd20, "irq_mtime_reach");
    chk("irq_not_yet", {31'd0, tmr_irq_r}, 32'd0);
    @(negedge clk);
    rd(32'h00, 32'd21, "irq_mtime_next");
    chk("irq_rise", {31'd0, tmr_irq_r}, 32'd1);
    wr(32'h08, 32'hFFFF_FFFF);
    chk("irq_still_high", {31'd0, tmr_irq_r}, 32'd1);
    @(negedge clk);
    chk("irq_fall", {31'd0, tmr_irq_r}, 32'd0);

    // Reserved offset and out-of-window stores change nothing
    wr(32'h14, 32'hDEAD_BEEF);
    wr(32'h20, 32'h0000_0009);
    wr(32'h30, 32'h0000_0005);
    rd(32'h14, 32'd0, "reserved_reads_0");
    rd(32'h20, 32'd0, "miss_reads_0");
    rd(32'h10, 32'd0, "prescale_after_miss");
    rd(32'h08, 32'hFFFF_FFFF, "cmp_lo_after_miss");
    rd(32'h0C, 32'd0, "cmp_hi_after_miss");

    // A low-half store on a tick cycle wins, with no carry even from all-ones
    wr(32'h04, 32'd0);
    wr(32'h00, 32'hFFFF_FFFF);
    wr(32'h00, 32'd7);
    rd(32'h00, 32'd7, "store_wins_lo");
    rd(32'h04, 32'd0, "store_no_carry_hi");
    @(negedge clk);
    rd(32'h00, 32'd8, "store_then_tick");

    // Reset while the interrupt is pending
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'd0);
    @(negedge clk);
    chk("irq_before_reset", {31'd0, tmr_irq_r}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("irq_after_reset", {31'd0, tmr_irq_r}, 32'd0);
    rd(32'h00, 32'd0, "mtime_after_reset");
    rd(32'h08, 32'hFFFF_FFFF, "cmp_after_reset");
    reset = 1'b0;
    @(negedge clk);
    rd(32'h00, 32'd1, "count_after_reset");
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
